// File: rtl/cv32e40p_pkg.sv
// Shared constants for the OBI arbiter slice: requester port indices and a
// small helper used by the round-robin priority pointer.
package cv32e40p_pkg;

  localparam int unsigned OBI_PORT_DATA  = 0;
  localparam int unsigned OBI_PORT_INSTR = 1;
  localparam int unsigned OBI_NUM_PORTS  = 2;

  // With two requesters, "the other index" is a simple inversion.
  function automatic logic obi_other_port(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/cv32e40p_obi_id_fifo.sv
// In-order FIFO of 1-bit requester IDs, one entry per granted OBI transfer
// that has not yet received its response.
module cv32e40p_obi_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage, pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_id;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (do_pop) rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_obi_arbiter.sv
// Two-requester OBI arbiter (data = 0, instruction = 1) onto one OBI master.
// Handshake: a transfer happens on a cycle where req and gnt are both high;
// a requester keeps req and its A-channel stable until it sees its gnt_o, and
// responses (rvalid) come back in grant order, one per granted transfer.
module cv32e40p_obi_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int NUM_OUTSTANDING = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [OBI_NUM_PORTS-1:0]        req_i,
  output logic [OBI_NUM_PORTS-1:0]        gnt_o,
  input  logic [OBI_NUM_PORTS-1:0][31:0]  addr_i,
  input  logic [OBI_NUM_PORTS-1:0]        we_i,
  input  logic [OBI_NUM_PORTS-1:0][3:0]   be_i,
  input  logic [OBI_NUM_PORTS-1:0][31:0]  wdata_i,
  input  logic [OBI_NUM_PORTS-1:0][5:0]   atop_i,
  output logic [OBI_NUM_PORTS-1:0]        rvalid_o,
  output logic [31:0]                     rdata_o,
  output logic                            err_o,
  output logic                            obi_req_o,
  input  logic                            obi_gnt_i,
  output logic [31:0]                     obi_addr_o,
  output logic                            obi_we_o,
  output logic [3:0]                      obi_be_o,
  output logic [31:0]                     obi_wdata_o,
  output logic [5:0]                      obi_atop_o,
  input  logic [31:0]                     obi_rdata_i,
  input  logic                            obi_rvalid_i,
  input  logic                            obi_err_i
);

  logic sel;         // requester currently presented on the OBI port
  logic mux_idx;     // A-channel source (index 0 when nothing is requested)
  logic prio_q;      // index favoured when both requesters ask
  logic lock_q;      // an ungranted request is pending on the OBI port
  logic lock_idx_q;  // which requester that pending request belongs to
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic push;
  logic pop;

  // Pick the requester: a stalled request stays selected, otherwise round-robin.
  always_comb begin
    sel = 1'(OBI_PORT_DATA);
    if (lock_q)                      sel = lock_idx_q;
    else if (&req_i)                 sel = prio_q;
    else if (req_i[OBI_PORT_INSTR])  sel = 1'(OBI_PORT_INSTR);
  end

  // Outstanding limit is judged from registered occupancy only (no pop bypass).
  assign obi_req_o = (|req_i) & ~fifo_full;
  assign push      = obi_req_o & obi_gnt_i;
  assign pop       = obi_rvalid_i & ~fifo_empty;
  assign mux_idx   = obi_req_o ? sel : 1'(OBI_PORT_DATA);

  assign obi_addr_o  = addr_i[mux_idx];
  assign obi_we_o    = we_i[mux_idx];
  assign obi_be_o    = be_i[mux_idx];
  assign obi_wdata_o = wdata_i[mux_idx];
  assign obi_atop_o  = atop_i[mux_idx];
  assign rdata_o     = obi_rdata_i;
  assign err_o       = obi_err_i;

  // Route the grant back to the selected requester only.
  always_comb begin
    gnt_o = '0;
    if (push) gnt_o[sel] = 1'b1;
  end

  // Route a response to the requester at the head of the ID FIFO.
  always_comb begin
    rvalid_o = '0;
    if (pop) rvalid_o[fifo_head] = 1'b1;
  end

  // Lock and round-robin pointer updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'(OBI_PORT_DATA);
      lock_q     <= 1'b0;
      lock_idx_q <= 1'(OBI_PORT_DATA);
    end else begin
      lock_q <= obi_req_o & ~obi_gnt_i;
      if (obi_req_o & ~obi_gnt_i) lock_idx_q <= sel;
      if (push)                   prio_q     <= obi_other_port(sel);
    end
  end

  cv32e40p_obi_id_fifo #(
    .DEPTH (NUM_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // A response with nothing outstanding is dropped; flag it in simulation.
  stray_rvalid_a : assert property (
    @(posedge clk) disable iff (!rst_n) !(obi_rvalid_i && fifo_empty)
  ) else $warning("obi arbiter: response received with no outstanding ID, ignored");

endmodule

// File: tb/tb_cv32e40p_obi_arbiter.sv
module tb_cv32e40p_obi_arbiter;

  localparam int NOUT = 2;
  localparam logic [31:0] A0 = 32'hD000_0010;
  localparam logic [31:0] A1 = 32'h1000_0020;
  localparam logic [31:0] W0 = 32'h0D0D_0D0D;
  localparam logic [31:0] W1 = 32'h1111_1111;

  // ---------------- clock / reset / signals ----------------
  logic             clk;
  logic             rst_n;
  logic [1:0]       req_i;
  logic [1:0]       gnt_o;
  logic [1:0][31:0] addr_i;
  logic [1:0]       we_i;
  logic [1:0][3:0]  be_i;
  logic [1:0][31:0] wdata_i;
  logic [1:0][5:0]  atop_i;
  logic [1:0]       rvalid_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic             obi_req_o;
  logic             obi_gnt_i;
  logic [31:0]      obi_addr_o;
  logic             obi_we_o;
  logic [3:0]       obi_be_o;
  logic [31:0]      obi_wdata_o;
  logic [5:0]       obi_atop_o;
  logic [31:0]      obi_rdata_i;
  logic             obi_rvalid_i;
  logic             obi_err_i;

  int vectors    = 0;
  int miscompares = 0;

  // scoreboard: IDs of granted-but-unanswered transfers, oldest first
  logic [0:0] exp_q[$];
  int m_prio;   // favoured requester
  int m_lock;   // requester holding an ungranted request, -1 if none

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cv32e40p_obi_arbiter #(.NUM_OUTSTANDING(NOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .atop_i       (atop_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .obi_req_o    (obi_req_o),
    .obi_gnt_i    (obi_gnt_i),
    .obi_addr_o   (obi_addr_o),
    .obi_we_o     (obi_we_o),
    .obi_be_o     (obi_be_o),
    .obi_wdata_o  (obi_wdata_o),
    .obi_atop_o   (obi_atop_o),
    .obi_rdata_i  (obi_rdata_i),
    .obi_rvalid_i (obi_rvalid_i),
    .obi_err_i    (obi_err_i)
  );

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req_i        = 2'b00;
    addr_i[0]    = A0;  addr_i[1]  = A1;
    we_i         = 2'b10;
    be_i[0]      = 4'h3; be_i[1]   = 4'hF;
    wdata_i[0]   = W0;  wdata_i[1] = W1;
    atop_i[0]    = 6'h00; atop_i[1] = 6'h2A;
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_rdata_i  = 32'h0;
    obi_err_i    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    m_prio = 0;
    m_lock = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // drive one cycle of requester/slave inputs at the falling edge
  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic err);
    @(negedge clk);
    req_i = req; obi_gnt_i = gnt; obi_rvalid_i = rv;
    obi_rdata_i = rdata; obi_err_i = err;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk); #1;
    vectors++;
    if (gnt_o !== 2'b00 || rvalid_o !== 2'b00 || obi_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: gnt=%b rvalid=%b req=%b want 00 00 0", gnt_o, rvalid_o, obi_req_o);
    end
    drive(2'b01, 1'b1, 1'b1, 32'h0, 1'b0);
    vectors++;
    if (gnt_o !== 2'b01 || obi_req_o !== 1'b1 || rvalid_o !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_req: gnt=%b req=%b rvalid=%b want 01 1 00", gnt_o, obi_req_o, rvalid_o);
    end
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    logic [1:0] eg, er;
    logic [31:0] ea;
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 1'b1, k > 0, 32'h0, 1'b0);
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      ea = (k % 2 == 0) ? A0 : A1;
      er = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      vectors++;
      if (gnt_o !== eg || obi_addr_o !== ea || rvalid_o !== er) begin
        miscompares++;
        $display("FAIL alternate[%0d]: gnt=%b addr=%h rvalid=%b want %b %h %b",
                 k, gnt_o, obi_addr_o, rvalid_o, eg, ea, er);
      end
    end
    drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
    vectors++;
    if (rvalid_o !== 2'b10) begin
      miscompares++;
      $display("FAIL alternate_drain: rvalid=%b want 10", rvalid_o);
    end
    do_reset();
  endtask

  task automatic test_lock();
    logic [1:0] reqs [5] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
    logic       gnts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] egnt [5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
    logic [31:0] ea;
    logic [31:0] ew;
    for (int k = 0; k < 5; k++) begin
      drive(reqs[k], gnts[k], 1'b0, 32'h0, 1'b0);
      ea = (k < 4) ? A1 : A0;
      ew = (k < 4) ? W1 : W0;
      vectors++;
      if (gnt_o !== egnt[k] || obi_addr_o !== ea || obi_wdata_o !== ew || obi_req_o !== 1'b1) begin
        miscompares++;
        $display("FAIL lock[%0d]: gnt=%b addr=%h wdata=%h req=%b want %b %h %h 1",
                 k, gnt_o, obi_addr_o, obi_wdata_o, obi_req_o, egnt[k], ea, ew);
      end
    end
    drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
    vectors++;
    if (rvalid_o !== 2'b10) begin
      miscompares++;
      $display("FAIL lock_resp1: rvalid=%b want 10", rvalid_o);
    end
    drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
    vectors++;
    if (rvalid_o !== 2'b01) begin
      miscompares++;
      $display("FAIL lock_resp0: rvalid=%b want 01", rvalid_o);
    end
    do_reset();
  endtask

  task automatic test_outstanding();
    for (int k = 0; k < 2; k++) begin
      drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (gnt_o !== 2'b01) begin
        miscompares++;
        $display("FAIL outst_grant[%0d]: gnt=%b want 01", k, gnt_o);
      end
    end
    // full: nothing issued, A-channel falls back to index 0
    drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obi_req_o !== 1'b0 || gnt_o !== 2'b00 || obi_addr_o !== A0 || obi_atop_o !== 6'h00) begin
      miscompares++;
      $display("FAIL outst_full: req=%b gnt=%b addr=%h atop=%h want 0 00 %h 00",
               obi_req_o, gnt_o, obi_addr_o, obi_atop_o, A0);
    end
    // pop in this cycle must not open the port in the same cycle
    drive(2'b01, 1'b1, 1'b1, 32'h0, 1'b0);
    vectors++;
    if (obi_req_o !== 1'b0 || rvalid_o !== 2'b01) begin
      miscompares++;
      $display("FAIL outst_nobypass: req=%b rvalid=%b want 0 01", obi_req_o, rvalid_o);
    end
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obi_req_o !== 1'b1 || gnt_o !== 2'b01) begin
      miscompares++;
      $display("FAIL outst_reopen: req=%b gnt=%b want 1 01", obi_req_o, gnt_o);
    end
    do_reset();
  endtask

  task automatic test_response();
    drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(2'b00, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0);
    vectors++;
    if (rvalid_o !== 2'b10 || rdata_o !== 32'hAAAA_0001 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_first: rvalid=%b rdata=%h err=%b want 10 aaaa0001 0", rvalid_o, rdata_o, err_o);
    end
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0BAD, 1'b1);
    vectors++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'h0000_0BAD || err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL resp_second: rvalid=%b rdata=%h err=%b want 01 00000bad 1", rvalid_o, rdata_o, err_o);
    end
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (rvalid_o !== 2'b00) begin
      miscompares++;
      $display("FAIL resp_quiet: rvalid=%b want 00", rvalid_o);
    end
    do_reset();
  endtask

  task automatic test_push_pop_same();
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(2'b01, 1'b1, 1'b1, 32'h0, 1'b0);
    vectors++;
    if (gnt_o !== 2'b01 || rvalid_o !== 2'b01) begin
      miscompares++;
      $display("FAIL pushpop: gnt=%b rvalid=%b want 01 01", gnt_o, rvalid_o);
    end
    // one outstanding left: exactly one more grant fits
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obi_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pushpop_room: req=%b want 1", obi_req_o);
    end
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (obi_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL pushpop_full: req=%b want 0", obi_req_o);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    do_reset();
    drive(2'b00, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    vectors++;
    if (rvalid_o !== 2'b00 || obi_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_resp: rvalid=%b req=%b want 00 0", rvalid_o, obi_req_o);
    end
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (obi_req_o !== (k < 2) || gnt_o !== ((k < 2) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL after_reset[%0d]: req=%b gnt=%b want %b", k, obi_req_o, gnt_o, (k < 2));
      end
    end
    do_reset();
  endtask

  task automatic test_random(input int cycles);
    logic [1:0]  pend;
    logic [1:0]  eg, er;
    logic        ereq;
    int          want;
    int          mux;
    pend = 2'b00;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p]    = 1'b1;
          addr_i[p]  = $urandom;
          we_i[p]    = 1'($urandom_range(0, 1));
          be_i[p]    = 4'($urandom_range(0, 15));
          wdata_i[p] = $urandom;
          atop_i[p]  = 6'($urandom_range(0, 63));
        end
      end
      req_i        = pend;
      obi_gnt_i    = ($urandom_range(0, 3) != 0);
      obi_rvalid_i = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      obi_rdata_i  = $urandom;
      obi_err_i    = 1'($urandom_range(0, 1));
      #1;
      // reference: stalled request wins, else favoured one, else whoever asks
      if (m_lock >= 0)       want = m_lock;
      else if (pend == 2'b11) want = m_prio;
      else if (pend[1])      want = 1;
      else                   want = 0;
      ereq = (pend != 2'b00) && (exp_q.size() < NOUT);
      mux  = ereq ? want : 0;
      eg   = 2'b00;
      if (ereq && obi_gnt_i) eg[want] = 1'b1;
      er   = 2'b00;
      if (obi_rvalid_i && exp_q.size() > 0) er[exp_q[0]] = 1'b1;
      vectors++;
      if (obi_req_o !== ereq || gnt_o !== eg || rvalid_o !== er) begin
        miscompares++;
        $display("FAIL rand_ctrl[%0d]: req=%b gnt=%b rvalid=%b want %b %b %b",
                 c, obi_req_o, gnt_o, rvalid_o, ereq, eg, er);
      end
      vectors++;
      if (obi_addr_o !== addr_i[mux] || obi_we_o !== we_i[mux] || obi_be_o !== be_i[mux] ||
          obi_wdata_o !== wdata_i[mux] || obi_atop_o !== atop_i[mux]) begin
        miscompares++;
        $display("FAIL rand_achan[%0d]: addr=%h we=%b be=%h wdata=%h atop=%h want port %0d",
                 c, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_atop_o, mux);
      end
      vectors++;
      if (rdata_o !== obi_rdata_i || err_o !== obi_err_i) begin
        miscompares++;
        $display("FAIL rand_rchan[%0d]: rdata=%h err=%b want %h %b", c, rdata_o, err_o, obi_rdata_i, obi_err_i);
      end
      // advance the reference at the coming clock edge
      if (er != 2'b00) void'(exp_q.pop_front());
      if (eg != 2'b00) begin
        exp_q.push_back(1'(want));
        pend[want] = 1'b0;
        m_prio     = 1 - want;
        m_lock     = -1;
      end else if (ereq) begin
        m_lock = want;
      end else begin
        m_lock = -1;
      end
    end
    do_reset();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    m_prio = 0;
    m_lock = -1;
    test_reset();
    test_alternate();
    test_lock();
    test_outstanding();
    test_response();
    test_push_pop_same();
    test_reset_mid();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
